// File: rtl/peak_result_streamer_pkg.sv
// -----------------------------------------------------------------------------
// peak_result_streamer_pkg
//  Shared constants and types for the peak result streamer and its bank
//  register file: frame sync word, record field widths, beat count of one
//  packet and the streaming FSM state encoding.
// -----------------------------------------------------------------------------
package peak_result_streamer_pkg;

  localparam int          NOF_RANGE_BINS = 16;
  localparam logic [15:0] HEADER_TAG     = 16'hA55A;

  localparam int BIN_W   = 4;
  localparam int VALUE_W = 32;
  localparam int ADDR_W  = 10;
  localparam int ENTRY_W = VALUE_W + ADDR_W;

  // header + one record per range bin + trailer
  localparam int BEAT_COUNT = NOF_RANGE_BINS + 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HEADER  = 2'd1;
  localparam logic [1:0] ST_RECORD  = 2'd2;
  localparam logic [1:0] ST_TRAILER = 2'd3;

  typedef struct packed {
    logic [VALUE_W-1:0] value;
    logic [ADDR_W-1:0]  addr;
  } peak_entry_t;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/peak_result_streamer_bank.sv
// -----------------------------------------------------------------------------
// peak_result_bank
//  One result bank: Depth entries of {peak value, FFT bin} plus a valid mask.
//  Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   clr_i          clear all entries and the mask
//   wr_en_i        write wr_entry_i into entry wr_bin_i and set its mask bit
//   rd_bin_i       combinational read address
//   rd_entry_o     entry at rd_bin_i, zero when its mask bit is clear
//   mask_o         per-bin valid mask
//  A clear and a write in the same cycle leave only the written entry.
// -----------------------------------------------------------------------------
module peak_result_bank
  import peak_result_streamer_pkg::*;
#(
  parameter int Depth = NOF_RANGE_BINS
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               wr_en_i,
  input  logic [BIN_W-1:0]   wr_bin_i,
  input  logic [ENTRY_W-1:0] wr_entry_i,
  input  logic [BIN_W-1:0]   rd_bin_i,
  output logic [ENTRY_W-1:0] rd_entry_o,
  output logic [Depth-1:0]   mask_o
);

  logic [ENTRY_W-1:0] entries [Depth];

  // write after clear so a result arriving with the clear survives it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        entries[i] <= '0;
      end
      mask_o <= '0;
    end else begin
      if (clr_i) begin
        for (int i = 0; i < Depth; i++) begin
          entries[i] <= '0;
        end
        mask_o <= '0;
      end
      if (wr_en_i) begin
        entries[wr_bin_i] <= wr_entry_i;
        mask_o[wr_bin_i]  <= 1'b1;
      end
    end
  end

  assign rd_entry_o = mask_o[rd_bin_i] ? entries[rd_bin_i] : '0;

endmodule

// File: rtl/peak_result_streamer.sv
// -----------------------------------------------------------------------------
// peak_result_streamer
//  Collects the per-range-bin peaks of one accumulation group into a write
//  bank, swaps banks on group_done_i and streams the closed bank as a framed
//  packet (header, NofRangeBins records, checksum trailer) on four 16-bit lanes.
//  Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   group_start_i                clear write bank (a coincident result is kept)
//   pk_valid_i/pk_bin_i/
//   pk_value_i/pk_addr_i         one peak result for range bin pk_bin_i
//   group_done_i                 close frame; dropped if still streaming
//   y0_o/y0z_o/y1_o/y1z_o        registered packet lanes, 0 when idle
//   data_valid_o                 lanes carry a packet beat
//   busy_o                       frame being streamed
//   overrun_o                    sticky: a frame was dropped
//   frame_cnt_o                  frames emitted, wrapping
// -----------------------------------------------------------------------------
module peak_result_streamer
  import peak_result_streamer_pkg::*;
#(
  parameter int          NofRangeBins = NOF_RANGE_BINS,
  parameter logic [15:0] HeaderTag    = HEADER_TAG
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               group_start_i,
  input  logic               pk_valid_i,
  input  logic [BIN_W-1:0]   pk_bin_i,
  input  logic [VALUE_W-1:0] pk_value_i,
  input  logic [ADDR_W-1:0]  pk_addr_i,
  input  logic               group_done_i,
  output logic [15:0]        y0_o,
  output logic [15:0]        y0z_o,
  output logic [15:0]        y1_o,
  output logic [15:0]        y1z_o,
  output logic               data_valid_o,
  output logic               busy_o,
  output logic               overrun_o,
  output logic [15:0]        frame_cnt_o
);

  localparam logic [BIN_W-1:0] LastBin = BIN_W'(NofRangeBins - 1);

  logic                    wr_sel;
  logic                    accept;
  logic                    drop;
  logic                    bin_ok;
  logic                    wr_en;
  logic                    clr0;
  logic                    clr1;
  logic                    wr0;
  logic                    wr1;
  logic [ENTRY_W-1:0]      wr_entry;
  logic [ENTRY_W-1:0]      entry0;
  logic [ENTRY_W-1:0]      entry1;
  logic [NofRangeBins-1:0] mask0;
  logic [NofRangeBins-1:0] mask1;
  logic [NofRangeBins-1:0] rd_mask;
  peak_entry_t             rd_entry;
  logic [1:0]              state;
  logic [BIN_W-1:0]        rec_bin;
  logic [15:0]             checksum;
  logic [15:0]             beat_y0;
  logic [15:0]             beat_y0z;
  logic [15:0]             beat_y1;
  logic [15:0]             beat_y1z;
  logic [15:0]             beat_sum;

  // busy spans from the accepting edge until data_valid_o drops after the trailer
  assign busy_o = (state != ST_IDLE) | data_valid_o;
  assign accept = group_done_i & ~busy_o;
  assign drop   = group_done_i & busy_o;

  assign bin_ok   = ({1'b0, pk_bin_i} < 5'(NofRangeBins));
  assign wr_en    = pk_valid_i & bin_ok & ~drop;
  assign wr_entry = {pk_value_i, pk_addr_i};

  // wr_sel names the bank being filled; on accept the other (reader) bank is
  // cleared so it is empty when it becomes the write bank at this same edge
  assign wr0  = wr_en & ~wr_sel;
  assign wr1  = wr_en & wr_sel;
  assign clr0 = wr_sel ? accept : (group_start_i | drop);
  assign clr1 = wr_sel ? (group_start_i | drop) : accept;

  peak_result_bank #(.Depth(NofRangeBins)) u_bank0 (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (clr0),
    .wr_en_i    (wr0),
    .wr_bin_i   (pk_bin_i),
    .wr_entry_i (wr_entry),
    .rd_bin_i   (rec_bin),
    .rd_entry_o (entry0),
    .mask_o     (mask0)
  );

  peak_result_bank #(.Depth(NofRangeBins)) u_bank1 (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (clr1),
    .wr_en_i    (wr1),
    .wr_bin_i   (pk_bin_i),
    .wr_entry_i (wr_entry),
    .rd_bin_i   (rec_bin),
    .rd_entry_o (entry1),
    .mask_o     (mask1)
  );

  assign rd_entry = wr_sel ? entry0 : entry1;
  assign rd_mask  = wr_sel ? mask0 : mask1;

  always_comb begin
    beat_y0  = '0;
    beat_y0z = '0;
    beat_y1  = '0;
    beat_y1z = '0;
    case (state)
      ST_HEADER: begin
        beat_y0  = HeaderTag;
        beat_y0z = frame_cnt_o;
        beat_y1  = 16'(rd_mask);
        beat_y1z = 16'(NofRangeBins);
      end
      ST_RECORD: begin
        beat_y0  = rd_entry.value[15:0];
        beat_y0z = rd_entry.value[31:16];
        beat_y1  = 16'(rd_entry.addr);
        beat_y1z = 16'(rec_bin);
      end
      ST_TRAILER: begin
        beat_y0  = checksum;
        beat_y0z = ~HeaderTag;
        beat_y1  = 16'(NofRangeBins) - 16'(popcount16(16'(rd_mask)));
        beat_y1z = '0;
      end
      default: begin
      end
    endcase
  end

  assign beat_sum = beat_y0 + beat_y0z + beat_y1 + beat_y1z;

  // checksum accumulates header and record beats as they are registered out
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      wr_sel       <= 1'b0;
      rec_bin      <= '0;
      checksum     <= '0;
      y0_o         <= '0;
      y0z_o        <= '0;
      y1_o         <= '0;
      y1z_o        <= '0;
      data_valid_o <= 1'b0;
      overrun_o    <= 1'b0;
      frame_cnt_o  <= '0;
    end else begin
      y0_o         <= beat_y0;
      y0z_o        <= beat_y0z;
      y1_o         <= beat_y1;
      y1z_o        <= beat_y1z;
      data_valid_o <= (state != ST_IDLE);
      if (accept) begin
        wr_sel <= ~wr_sel;
      end
      if (drop) begin
        overrun_o <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          checksum <= beat_sum;
          rec_bin  <= '0;
          state    <= ST_RECORD;
        end
        ST_RECORD: begin
          checksum <= checksum + beat_sum;
          rec_bin  <= rec_bin + 4'd1;
          if (rec_bin == LastBin) begin
            state <= ST_TRAILER;
          end
        end
        default: begin
          frame_cnt_o <= frame_cnt_o + 16'd1;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_peak_result_streamer.sv
// -----------------------------------------------------------------------------
// tb_peak_result_streamer
//  Scoreboard bench: stimulus updates a bin-table model of the write bank and,
//  on each accepted group_done, pushes the whole expected packet into a queue.
//  A negedge monitor pops one beat per data_valid_o cycle and compares lanes.
// -----------------------------------------------------------------------------
module tb_peak_result_streamer;

  localparam int          NBINS = 16;
  localparam logic [15:0] TAG   = 16'hA55A;
  localparam int          BEATS = NBINS + 2;

  logic        clk_i;
  logic        rst_i;
  logic        group_start_i;
  logic        pk_valid_i;
  logic [3:0]  pk_bin_i;
  logic [31:0] pk_value_i;
  logic [9:0]  pk_addr_i;
  logic        group_done_i;
  logic [15:0] y0_o;
  logic [15:0] y0z_o;
  logic [15:0] y1_o;
  logic [15:0] y1z_o;
  logic        data_valid_o;
  logic        busy_o;
  logic        overrun_o;
  logic [15:0] frame_cnt_o;

  peak_result_streamer dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .group_start_i (group_start_i),
    .pk_valid_i    (pk_valid_i),
    .pk_bin_i      (pk_bin_i),
    .pk_value_i    (pk_value_i),
    .pk_addr_i     (pk_addr_i),
    .group_done_i  (group_done_i),
    .y0_o          (y0_o),
    .y0z_o         (y0z_o),
    .y1_o          (y1_o),
    .y1z_o         (y1z_o),
    .data_valid_o  (data_valid_o),
    .busy_o        (busy_o),
    .overrun_o     (overrun_o),
    .frame_cnt_o   (frame_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int beat_no = 0;

  logic [63:0] exp_q[$];

  logic [31:0] m_val  [NBINS];
  logic [9:0]  m_addr [NBINS];
  bit          m_has  [NBINS];
  int          m_frames;
  bit          m_overrun;
  bit          m_ever;
  int          m_last_accept;

  function automatic void model_clear();
    for (int b = 0; b < NBINS; b++) begin
      m_val[b]  = '0;
      m_addr[b] = '0;
      m_has[b]  = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    model_clear();
    m_frames      = 0;
    m_overrun     = 1'b0;
    m_ever        = 1'b0;
    m_last_accept = 0;
    exp_q.delete();
  endfunction

  function automatic void close_frame();
    int          sum;
    int          missing;
    logic [15:0] mask;
    logic [15:0] l0, l1, l2, l3;
    sum = 0;
    missing = 0;
    mask = '0;
    for (int b = 0; b < NBINS; b++) begin
      if (m_has[b]) mask[b] = 1'b1;
      else missing++;
    end
    l0 = TAG; l1 = 16'(m_frames); l2 = mask; l3 = 16'(NBINS);
    sum = sum + l0 + l1 + l2 + l3;
    exp_q.push_back({l0, l1, l2, l3});
    for (int b = 0; b < NBINS; b++) begin
      l0 = m_has[b] ? m_val[b][15:0] : 16'h0;
      l1 = m_has[b] ? m_val[b][31:16] : 16'h0;
      l2 = m_has[b] ? 16'(m_addr[b]) : 16'h0;
      l3 = 16'(b);
      sum = sum + l0 + l1 + l2 + l3;
      exp_q.push_back({l0, l1, l2, l3});
    end
    exp_q.push_back({16'(sum), ~TAG, 16'(missing), 16'h0});
    m_frames = (m_frames + 1) % 65536;
    model_clear();
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // one clock: drive inputs, take the edge, update the model as the DUT would
  task automatic applyStimulus(input logic start, input logic valid, input logic [3:0] bin,
                               input logic [31:0] val, input logic [9:0] addr, input logic done);
    bit streaming;
    group_start_i = start;
    pk_valid_i    = valid;
    pk_bin_i      = bin;
    pk_value_i    = val;
    pk_addr_i     = addr;
    group_done_i  = done;
    @(posedge clk_i);
    edge_cnt++;
    streaming = m_ever && ((edge_cnt - m_last_accept) <= BEATS);
    if (done && streaming) begin
      m_overrun = 1'b1;
      model_clear();
    end else begin
      if (start) model_clear();
      if (valid && (int'(bin) < NBINS)) begin
        m_val[bin]  = val;
        m_addr[bin] = addr;
        m_has[bin]  = 1'b1;
      end
      if (done) begin
        close_frame();
        m_last_accept = edge_cnt;
        m_ever        = 1'b1;
      end
    end
    #1;
    group_start_i = 1'b0;
    pk_valid_i    = 1'b0;
    group_done_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 10'd0, 1'b0);
  endtask

  task automatic writePeak(input logic [3:0] bin, input logic [31:0] val, input logic [9:0] addr);
    applyStimulus(1'b0, 1'b1, bin, val, addr, 1'b0);
  endtask

  task automatic doneOnly();
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 10'd0, 1'b1);
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    while (busy_o && guard < 200) begin
      idle(1);
      guard++;
    end
    checkOutput("wait_idle_busy", {31'd0, busy_o}, 32'd0);
  endtask

  // monitor: every non-reset cycle either a packet beat or quiet zero lanes
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (data_valid_o) begin
        checks++;
        beat_no++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL beat_unexpected got %h%h%h%h expected none",
                   y0_o, y0z_o, y1_o, y1z_o);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          if ({y0_o, y0z_o, y1_o, y1z_o} !== e) begin
            errors++;
            $display("[TB] FAIL beat_%0d lanes got %h expected %h", beat_no,
                     {y0_o, y0z_o, y1_o, y1z_o}, e);
          end
        end
      end else begin
        checks++;
        if ({y0_o, y0z_o, y1_o, y1z_o} !== 64'h0) begin
          errors++;
          $display("[TB] FAIL idle_lanes got %h expected 0", {y0_o, y0z_o, y1_o, y1z_o});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_i         = 1'b1;
    group_start_i = 1'b0;
    pk_valid_i    = 1'b0;
    pk_bin_i      = '0;
    pk_value_i    = '0;
    pk_addr_i     = '0;
    group_done_i  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("reset_lanes", {y0_o, y0z_o} | {y1_o, y1z_o}, 32'd0);
    checkOutput("reset_valid", {31'd0, data_valid_o}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("reset_overrun", {31'd0, overrun_o}, 32'd0);
    checkOutput("reset_frame_cnt", {16'd0, frame_cnt_o}, 32'd0);
    rst_i = 1'b0;

    $display("[TB] single result in bin 3");
    writePeak(4'd3, 32'h0001_0002, 10'h055);
    doneOnly();
    checkOutput("busy_after_done", {31'd0, busy_o}, 32'd1);
    waitIdle();
    checkOutput("frame_cnt_first", {16'd0, frame_cnt_o}, 32'd1);

    $display("[TB] all bins written");
    for (int b = 0; b < NBINS; b++) writePeak(4'(b), $urandom, 10'($urandom));
    doneOnly();
    waitIdle();
    checkOutput("frame_cnt_full", {16'd0, frame_cnt_o}, 32'd2);

    $display("[TB] second done while streaming");
    writePeak(4'd9, 32'hCAFE_0001, 10'h3FF);
    doneOnly();
    idle(4);
    writePeak(4'd2, 32'h1234_5678, 10'h111);
    doneOnly();
    checkOutput("overrun_set", {31'd0, overrun_o}, 32'd1);
    waitIdle();
    checkOutput("frame_cnt_overrun", {16'd0, frame_cnt_o}, 32'd3);
    idle(2);
    checkOutput("overrun_sticky", {31'd0, overrun_o}, 32'd1);

    $display("[TB] result coincident with done");
    applyStimulus(1'b0, 1'b1, 4'd7, 32'h0000_7777, 10'h077, 1'b1);
    waitIdle();

    $display("[TB] result coincident with group start");
    writePeak(4'd1, 32'h1111_1111, 10'h001);
    applyStimulus(1'b1, 1'b1, 4'd4, 32'h4444_4444, 10'h044, 1'b0);
    doneOnly();
    waitIdle();

    $display("[TB] bin 15 written twice");
    writePeak(4'd15, 32'h10, 10'h010);
    writePeak(4'd15, 32'h20, 10'h020);
    doneOnly();
    waitIdle();

    $display("[TB] reset in the middle of a packet");
    writePeak(4'd5, 32'h5555_AAAA, 10'h155);
    doneOnly();
    idle(9);
    rst_i = 1'b1;
    #1;
    checkOutput("abort_lanes", {y0_o, y0z_o} | {y1_o, y1z_o}, 32'd0);
    checkOutput("abort_valid", {31'd0, data_valid_o}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("abort_overrun", {31'd0, overrun_o}, 32'd0);
    checkOutput("abort_frame_cnt", {16'd0, frame_cnt_o}, 32'd0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    writePeak(4'd0, 32'h0000_00AB, 10'h0CD);
    doneOnly();
    waitIdle();
    checkOutput("frame_cnt_after_abort", {16'd0, frame_cnt_o}, 32'd1);

    $display("[TB] random groups");
    for (int g = 0; g < 25; g++) begin
      int nwr;
      nwr = $urandom_range(0, 20);
      for (int w = 0; w < nwr; w++) begin
        applyStimulus(1'((w == 0) && ($urandom_range(0, 2) == 0)), 1'b1,
                      4'($urandom_range(0, 15)), $urandom, 10'($urandom), 1'b0);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      waitIdle();
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    $urandom, 10'($urandom), 1'b1);
    end
    waitIdle();
    idle(2);

    checkOutput("queue_drained", exp_q.size(), 32'd0);
    checkOutput("frame_cnt_final", {16'd0, frame_cnt_o}, 32'(m_frames));
    checkOutput("overrun_final", {31'd0, overrun_o}, {31'd0, m_overrun});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
